decode_exec_pipe: RTL and testbench

//  Two-stage decode/execute pipeline for 32-bit R-type instructions. Holds the register file,

---
 rtl/decode_exec_pipe.sv | 157 +++++++++++++++
 tb/tb_decode_exec_pipe.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_exec_pipe.sv
// Two-stage R-type decode/execute pipeline with register file,
// result forwarding and valid/ready handshakes on both sides.
module decode_exec_pipe #(
    parameter int N          = 32,
    parameter int NREGS      = 32,
    parameter int RESET_REGS = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  instr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic [4:0]   out_rd,
    output logic         out_illegal,
    input  logic         ld_en,
    input  logic [4:0]   ld_addr,
    input  logic [N-1:0] ld_data
);

    localparam int SH = $clog2(N);

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_ILL
    } alu_op_t;

    logic [N-1:0] regs [NREGS];

    alu_op_t      dec_op;
    alu_op_t      s1_op;
    logic         s1_valid;
    logic [4:0]   s1_rd;
    logic [N-1:0] s1_a;
    logic [N-1:0] s1_b;
    logic [N-1:0] alu_res;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic         s1_adv;
    logic         in_fire;
    logic         wb_en;

    wire [4:0] rd_f = instr[11:7];
    wire [4:0] rs_b = instr[19:15];
    wire [4:0] rs_a = instr[24:20];

    assign s1_adv   = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s1_adv;
    assign in_fire  = in_valid && in_ready;
    assign wb_en    = s1_adv && (s1_op != ALU_ILL) && (s1_rd != 5'd0)
                      && (32'(s1_rd) < NREGS);

    always_comb begin
        dec_op = ALU_ILL;
        if (instr[6:0] == 7'h33) begin
            case ({instr[31:25], instr[14:12]})
                {7'h00, 3'd0}: dec_op = ALU_ADD;
                {7'h20, 3'd0}: dec_op = ALU_SUB;
                {7'h00, 3'd1}: dec_op = ALU_SLL;
                {7'h00, 3'd2}: dec_op = ALU_SLT;
                {7'h00, 3'd3}: dec_op = ALU_SLTU;
                {7'h00, 3'd4}: dec_op = ALU_XOR;
                {7'h00, 3'd5}: dec_op = ALU_SRL;
                {7'h20, 3'd5}: dec_op = ALU_SRA;
                {7'h00, 3'd6}: dec_op = ALU_OR;
                {7'h00, 3'd7}: dec_op = ALU_AND;
                default:       dec_op = ALU_ILL;
            endcase
        end
    end

    // Operand read; the instruction leaving S1 this cycle forwards its result.
    always_comb begin
        op_a = '0;
        if (wb_en && rs_a == s1_rd)
            op_a = alu_res;
        else if (rs_a != 5'd0 && 32'(rs_a) < NREGS)
            op_a = regs[rs_a];
    end

    always_comb begin
        op_b = '0;
        if (wb_en && rs_b == s1_rd)
            op_b = alu_res;
        else if (rs_b != 5'd0 && 32'(rs_b) < NREGS)
            op_b = regs[rs_b];
    end

    always_comb begin
        alu_res = '0;
        case (s1_op)
            ALU_ADD:  alu_res = s1_a + s1_b;
            ALU_SUB:  alu_res = s1_a - s1_b;
            ALU_SLL:  alu_res = s1_a << s1_b[SH-1:0];
            ALU_SLT:  alu_res = {{(N-1){1'b0}}, $signed(s1_a) < $signed(s1_b)};
            ALU_SLTU: alu_res = {{(N-1){1'b0}}, s1_a < s1_b};
            ALU_XOR:  alu_res = s1_a ^ s1_b;
            ALU_SRL:  alu_res = s1_a >> s1_b[SH-1:0];
            ALU_SRA:  alu_res = $unsigned($signed(s1_a) >>> s1_b[SH-1:0]);
            ALU_OR:   alu_res = s1_a | s1_b;
            ALU_AND:  alu_res = s1_a & s1_b;
            default:  alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= ALU_ILL;
            s1_rd    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_op    <= dec_op;
            s1_rd    <= rd_f;
            s1_a     <= op_a;
            s1_b     <= op_b;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            result      <= '0;
            out_rd      <= '0;
            out_illegal <= 1'b0;
        end else if (s1_adv) begin
            out_valid   <= 1'b1;
            result      <= alu_res;
            out_rd      <= s1_rd;
            out_illegal <= (s1_op == ALU_ILL);
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

    // Writeback is assigned after the preload so it wins on the same address.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (RESET_REGS != 0) begin
                for (int i = 0; i < NREGS; i++)
                    regs[i] <= '0;
            end
        end else begin
            if (ld_en && ld_addr != 5'd0 && 32'(ld_addr) < NREGS)
                regs[ld_addr] <= ld_data;
            if (wb_en)
                regs[s1_rd] <= alu_res;
        end
    end

endmodule

// File: tb/tb_decode_exec_pipe.sv
// Directed self-checking bench for decode_exec_pipe.
module tb_decode_exec_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  out_rd;
    logic        out_illegal;
    logic        ld_en;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_exec_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_rd(out_rd), .out_illegal(out_illegal),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    function automatic logic [31:0] rtype(input logic [6:0] f7,
                                          input logic [4:0] ra,
                                          input logic [4:0] rb,
                                          input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, ra, rb, f3, rd, 7'h33};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        step();
        ld_en = 1'b0;
    endtask

    // Send one instruction into an idle pipe and wait for it to reach the output.
    task automatic issue(input logic [31:0] i);
        in_valid = 1'b1; instr = i;
        step();
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; instr = '0; out_ready = 1'b1;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        step(); step();
        rst = 1'b0;
        #1;
        if (out_valid !== 1'b0) begin errors++;
            $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++;
            $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        checks++;
        if (result !== 32'd0) begin errors++;
            $display("FAIL rst_result got %h exp 0", result); end
        checks++;
        if (out_rd !== 5'd0 || out_illegal !== 1'b0) begin errors++;
            $display("FAIL rst_rd_ill got %0d/%b exp 0/0", out_rd, out_illegal); end
        checks++;
    endtask

    task automatic test_basic();
        preload(5'd1, 32'd5);
        preload(5'd2, 32'd7);
        in_valid = 1'b1; instr = 32'h001101B3;
        step();
        in_valid = 1'b0;
        if (out_valid !== 1'b0) begin errors++;
            $display("FAIL basic_early_valid got %b exp 0", out_valid); end
        checks++;
        step();
        if (out_valid !== 1'b1) begin errors++;
            $display("FAIL basic_valid got %b exp 1", out_valid); end
        checks++;
        if (result !== 32'd12) begin errors++;
            $display("FAIL basic_result got %h exp %h", result, 32'd12); end
        checks++;
        if (out_rd !== 5'd3 || out_illegal !== 1'b0) begin errors++;
            $display("FAIL basic_rd_ill got %0d/%b exp 3/0", out_rd, out_illegal); end
        checks++;
        step();
        if (out_valid !== 1'b0) begin errors++;
            $display("FAIL basic_drain got %b exp 0", out_valid); end
        checks++;
    endtask

    task automatic test_back_to_back();
        preload(5'd3, 32'd0);
        out_ready = 1'b1;
        in_valid = 1'b1; instr = rtype(7'h00, 5'd1, 5'd2, 3'd0, 5'd3);
        step();
        instr = rtype(7'h20, 5'd3, 5'd1, 3'd0, 5'd4);
        step();
        in_valid = 1'b0;
        if (out_valid !== 1'b1 || result !== 32'd12 || out_rd !== 5'd3) begin
            errors++;
            $display("FAIL b2b_first got v%b %h rd%0d exp v1 %h rd3",
                     out_valid, result, out_rd, 32'd12);
        end
        checks++;
        step();
        if (out_valid !== 1'b1 || result !== 32'd7 || out_rd !== 5'd4) begin
            errors++;
            $display("FAIL b2b_second got v%b %h rd%0d exp v1 %h rd4",
                     out_valid, result, out_rd, 32'd7);
        end
        checks++;
        step();
    endtask

    task automatic test_stall();
        logic [31:0] prog [3];
        logic [31:0] expv [3];
        logic [31:0] got  [$];
        int sent = 0;
        logic fired;
        prog[0] = rtype(7'h00, 5'd1, 5'd2, 3'd0, 5'd5); expv[0] = 32'd12;
        prog[1] = rtype(7'h20, 5'd2, 5'd1, 3'd0, 5'd6); expv[1] = 32'd2;
        prog[2] = rtype(7'h00, 5'd1, 5'd2, 3'd6, 5'd7); expv[2] = 32'd7;
        for (int c = 0; c < 30 && got.size() < 3; c++) begin
            out_ready = (c >= 7);
            in_valid = (sent < 3);
            instr = (sent < 3) ? prog[sent] : 32'd0;
            #1;
            if (c >= 2 && c <= 6) begin
                if (result !== 32'd12 || out_valid !== 1'b1) begin errors++;
                    $display("FAIL stall_hold c%0d got v%b %h exp v1 %h",
                             c, out_valid, result, 32'd12); end
                checks++;
            end
            if (c == 6) begin
                if (in_ready !== 1'b0) begin errors++;
                    $display("FAIL stall_in_ready got %b exp 0", in_ready); end
                checks++;
                if (out_rd !== 5'd5) begin errors++;
                    $display("FAIL stall_rd got %0d exp 5", out_rd); end
                checks++;
            end
            fired = in_valid && in_ready;
            if (out_valid && out_ready) got.push_back(result);
            step();
            if (fired) sent++;
        end
        in_valid = 1'b0;
        if (got.size() != 3) begin errors++;
            $display("FAIL stall_count got %0d exp 3", got.size()); end
        checks++;
        for (int k = 0; k < 3 && k < got.size(); k++) begin
            if (got[k] !== expv[k]) begin errors++;
                $display("FAIL stall_order%0d got %h exp %h", k, got[k], expv[k]); end
            checks++;
        end
        step();
        if (out_valid !== 1'b0) begin errors++;
            $display("FAIL stall_dup got %b exp 0", out_valid); end
        checks++;
    endtask

    task automatic test_alu_edges();
        logic [31:0] vec [5];
        logic [31:0] expv [5];
        out_ready = 1'b1;
        preload(5'd1, 32'h80000000);
        preload(5'd2, 32'd4);
        vec[0] = rtype(7'h20, 5'd1, 5'd2, 3'd5, 5'd8); expv[0] = 32'hF8000000;
        vec[1] = rtype(7'h00, 5'd1, 5'd2, 3'd5, 5'd8); expv[1] = 32'h08000000;
        vec[2] = rtype(7'h00, 5'd1, 5'd2, 3'd2, 5'd8); expv[2] = 32'd1;
        vec[3] = rtype(7'h00, 5'd1, 5'd2, 3'd3, 5'd8); expv[3] = 32'd0;
        vec[4] = rtype(7'h00, 5'd2, 5'd2, 3'd1, 5'd8); expv[4] = 32'd64;
        for (int k = 0; k < 5; k++) begin
            issue(vec[k]);
            if (out_valid !== 1'b1 || result !== expv[k]) begin errors++;
                $display("FAIL alu%0d got v%b %h exp v1 %h",
                         k, out_valid, result, expv[k]); end
            checks++;
        end
        preload(5'd1, 32'hFFFFFFFF);
        preload(5'd2, 32'd1);
        issue(rtype(7'h00, 5'd1, 5'd2, 3'd0, 5'd8));
        if (result !== 32'd0) begin errors++;
            $display("FAIL add_wrap got %h exp 0", result); end
        checks++;
        step();
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        preload(5'd1, 32'd5);
        preload(5'd2, 32'd7);
        preload(5'd9, 32'h55);
        issue({7'h00, 5'd1, 5'd2, 3'd0, 5'd9, 7'h13});
        if (out_illegal !== 1'b1 || result !== 32'd0) begin errors++;
            $display("FAIL ill_op got %b/%h exp 1/0", out_illegal, result); end
        checks++;
        issue(rtype(7'h01, 5'd1, 5'd2, 3'd0, 5'd9));
        if (out_illegal !== 1'b1 || result !== 32'd0) begin errors++;
            $display("FAIL ill_f7 got %b/%h exp 1/0", out_illegal, result); end
        checks++;
        issue(rtype(7'h00, 5'd9, 5'd0, 3'd0, 5'd10));
        if (result !== 32'h55) begin errors++;
            $display("FAIL ill_nowrite got %h exp %h", result, 32'h55); end
        checks++;
        issue(rtype(7'h00, 5'd1, 5'd2, 3'd0, 5'd0));
        if (result !== 32'd12 || out_rd !== 5'd0) begin errors++;
            $display("FAIL x0_dest got %h rd%0d exp %h rd0", result, out_rd, 32'd12); end
        checks++;
        issue(rtype(7'h00, 5'd0, 5'd1, 3'd0, 5'd11));
        if (result !== 32'd5) begin errors++;
            $display("FAIL x0_read got %h exp %h", result, 32'd5); end
        checks++;
        step();
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        in_valid = 1'b1; instr = rtype(7'h00, 5'd1, 5'd2, 3'd0, 5'd13);
        step();
        instr = rtype(7'h20, 5'd2, 5'd1, 3'd0, 5'd13);
        step();
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++;
            $display("FAIL full_pre got r%b v%b exp r0 v1", in_ready, out_valid); end
        checks++;
        rst = 1'b1;
        ld_en = 1'b1; ld_addr = 5'd2; ld_data = 32'd99;
        step();
        rst = 1'b0; in_valid = 1'b0; ld_en = 1'b0; out_ready = 1'b1;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd0) begin
            errors++;
            $display("FAIL full_rst got v%b r%b %h exp v0 r1 0",
                     out_valid, in_ready, result);
        end
        checks++;
        issue(rtype(7'h00, 5'd1, 5'd2, 3'd0, 5'd14));
        if (out_valid !== 1'b1 || result !== 32'd0 || out_rd !== 5'd14) begin
            errors++;
            $display("FAIL regs_cleared got v%b %h rd%0d exp v1 0 rd14",
                     out_valid, result, out_rd);
        end
        checks++;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_alu_edges();
        test_illegal();
        test_reset_full();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
